// File: rtl/map_if.sv
// Command/response channel bundle for map_pipelined: valid/ready command in,
// registered valid/ready response out.
interface map_if #(
   parameter int unsigned KEY_WIDTH   = 8,
   parameter int unsigned VALUE_WIDTH = 16,
   parameter int unsigned MAP_SIZE    = 16
);
   localparam int unsigned IDX_W = $clog2(MAP_SIZE);

   logic                   cmd_valid;
   logic                   cmd_ready;
   logic [1:0]             cmd_op;
   logic [KEY_WIDTH-1:0]   cmd_key;
   logic [VALUE_WIDTH-1:0] cmd_value;
   logic                   rsp_valid;
   logic                   rsp_ready;
   logic [2:0]             rsp_status;
   logic [VALUE_WIDTH-1:0] rsp_value;
   logic [IDX_W-1:0]       rsp_index;

   modport master (
      output cmd_valid, cmd_op, cmd_key, cmd_value, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_status, rsp_value, rsp_index
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_key, cmd_value, rsp_ready,
      output cmd_ready, rsp_valid, rsp_status, rsp_value, rsp_index
   );
endinterface

// File: rtl/map_pipelined.sv
// Registered key/value map: one command per cycle, free-list slot allocation,
// registered response with status, value and slot index.
module map_pipelined #(
   parameter int unsigned  KEY_WIDTH   = 8,
   parameter int unsigned  VALUE_WIDTH = 16,
   parameter int unsigned  MAP_SIZE    = 16,
   localparam int unsigned IDX_W       = $clog2(MAP_SIZE),
   localparam int unsigned CNT_W       = $clog2(MAP_SIZE + 1)
) (
   input  logic             clk,
   input  logic             reset_n,
   map_if.slave             bus,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);
   typedef enum logic [1:0] {
      OP_CLEAR  = 2'd0,
      OP_INSERT = 2'd1,
      OP_DELETE = 2'd2,
      OP_LOOKUP = 2'd3
   } op_e;

   typedef enum logic [2:0] {
      ST_HIT      = 3'd0,
      ST_MISS     = 3'd1,
      ST_INSERTED = 3'd2,
      ST_UPDATED  = 3'd3,
      ST_DELETED  = 3'd4,
      ST_FULL     = 3'd5,
      ST_CLEARED  = 3'd6
   } status_e;

   logic [KEY_WIDTH-1:0]   key_q   [MAP_SIZE];
   logic [KEY_WIDTH-1:0]   key_d   [MAP_SIZE];
   logic [VALUE_WIDTH-1:0] val_q   [MAP_SIZE];
   logic [VALUE_WIDTH-1:0] val_d   [MAP_SIZE];
   logic [IDX_W-1:0]       free_q  [MAP_SIZE];
   logic [IDX_W-1:0]       free_d  [MAP_SIZE];
   logic [MAP_SIZE-1:0]    valid_q, valid_d;
   logic [IDX_W-1:0]       rd_q, rd_d, wr_q, wr_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   rsp_valid_q, rsp_valid_d;
   status_e                rsp_status_q, rsp_status_d;
   logic [VALUE_WIDTH-1:0] rsp_value_q, rsp_value_d;
   logic [IDX_W-1:0]       rsp_index_q, rsp_index_d;

   logic                   hit;
   logic [IDX_W-1:0]       hit_idx;
   logic [IDX_W-1:0]       alloc_idx;
   logic                   accept;
   logic                   is_full;

   assign bus.cmd_ready  = ~rsp_valid_q | bus.rsp_ready;
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_status = rsp_status_q;
   assign bus.rsp_value  = rsp_value_q;
   assign bus.rsp_index  = rsp_index_q;
   assign count          = cnt_q;
   assign is_full        = (cnt_q == CNT_W'(MAP_SIZE));
   assign full           = is_full;
   assign empty          = (cnt_q == '0);
   assign accept         = bus.cmd_valid & bus.cmd_ready;
   assign alloc_idx      = free_q[rd_q];

   // Ascending scan: a later match overrides, so the highest index wins.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int unsigned i = 0; i < MAP_SIZE; i++) begin
         if (valid_q[i] && key_q[i] == bus.cmd_key) begin
            hit     = 1'b1;
            hit_idx = IDX_W'(i);
         end
      end
   end

   always_comb begin
      key_d        = key_q;
      val_d        = val_q;
      free_d       = free_q;
      valid_d      = valid_q;
      rd_d         = rd_q;
      wr_d         = wr_q;
      cnt_d        = cnt_q;
      rsp_valid_d  = rsp_valid_q & ~bus.rsp_ready;
      rsp_status_d = rsp_status_q;
      rsp_value_d  = rsp_value_q;
      rsp_index_d  = rsp_index_q;
      if (accept) begin
         rsp_valid_d = 1'b1;
         rsp_value_d = '0;
         rsp_index_d = '0;
         case (op_e'(bus.cmd_op))
            OP_CLEAR: begin
               valid_d = '0;
               rd_d    = '0;
               wr_d    = '0;
               cnt_d   = '0;
               for (int unsigned i = 0; i < MAP_SIZE; i++) free_d[i] = IDX_W'(i);
               rsp_status_d = ST_CLEARED;
            end
            OP_INSERT: begin
               if (hit) begin
                  val_d[hit_idx] = bus.cmd_value;
                  rsp_status_d   = ST_UPDATED;
                  rsp_value_d    = bus.cmd_value;
                  rsp_index_d    = hit_idx;
               end else if (!is_full) begin
                  key_d[alloc_idx]   = bus.cmd_key;
                  val_d[alloc_idx]   = bus.cmd_value;
                  valid_d[alloc_idx] = 1'b1;
                  rd_d               = rd_q + 1'b1;
                  cnt_d              = cnt_q + 1'b1;
                  rsp_status_d       = ST_INSERTED;
                  rsp_index_d        = alloc_idx;
               end else begin
                  rsp_status_d = ST_FULL;
               end
            end
            OP_DELETE: begin
               if (hit) begin
                  valid_d[hit_idx] = 1'b0;
                  free_d[wr_q]     = hit_idx;
                  wr_d             = wr_q + 1'b1;
                  cnt_d            = cnt_q - 1'b1;
                  rsp_status_d     = ST_DELETED;
                  rsp_value_d      = val_q[hit_idx];
                  rsp_index_d      = hit_idx;
               end else begin
                  rsp_status_d = ST_MISS;
               end
            end
            OP_LOOKUP: begin
               if (hit) begin
                  rsp_status_d = ST_HIT;
                  rsp_value_d  = val_q[hit_idx];
                  rsp_index_d  = hit_idx;
               end else begin
                  rsp_status_d = ST_MISS;
               end
            end
         endcase
      end
   end

   // Key/value payload is only ever read through valid_q, so it needs no reset.
   always_ff @(posedge clk) begin
      key_q <= key_d;
      val_q <= val_d;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_q      <= '0;
         rd_q         <= '0;
         wr_q         <= '0;
         cnt_q        <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_status_q <= ST_HIT;
         rsp_value_q  <= '0;
         rsp_index_q  <= '0;
         for (int unsigned i = 0; i < MAP_SIZE; i++) free_q[i] <= IDX_W'(i);
      end else begin
         valid_q      <= valid_d;
         rd_q         <= rd_d;
         wr_q         <= wr_d;
         cnt_q        <= cnt_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_status_q <= rsp_status_d;
         rsp_value_q  <= rsp_value_d;
         rsp_index_q  <= rsp_index_d;
         free_q       <= free_d;
      end
   end
endmodule

// File: doc/map_pipelined.md
# map_pipelined

Registered, back-pressurable key/value map: the next generation of the team's combinational-lookup map. It accepts one command per cycle on a valid/ready command channel and returns a registered response carrying a status code, value and slot index on a valid/ready response channel. It also exposes occupancy, full and empty flags. It adds three things the previous map lacks: a CLEAR operation, explicit full and miss reporting, and returning the old value on delete. It sits between a request arbiter and any client that needs associative storage.

## Interface
- KEY_WIDTH, 8, key bits
- VALUE_WIDTH, 16, value bits
- MAP_SIZE, 16, number of slots; power of two, ≥2
- IDX_W, $clog2(MAP_SIZE), slot index width (derived)
- CNT_W, $clog2(MAP_SIZE+1), occupancy width (derived)

- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_op  in  2  0 CLEAR, 1 INSERT, 2 DELETE, 3 LOOKUP
- cmd_key  in  KEY_WIDTH  key
- cmd_value  in  VALUE_WIDTH  value (INSERT only)
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_status  out  3  0 HIT, 1 MISS, 2 INSERTED, 3 UPDATED, 4 DELETED, 5 FULL, 6 CLEARED
- rsp_value  out  VALUE_WIDTH  looked-up, updated or deleted value; 0 otherwise
- rsp_index  out  IDX_W  slot touched; 0 on MISS/FULL/CLEARED
- count  out  CNT_W  valid entries
- full  out  1  count == MAP_SIZE
- empty  out  1  count == 0

## Operation
- Storage: per-slot key and value registers, a slot valid vector, a free-list FIFO of MAP_SIZE×IDX_W entries, and rd_ptr/wr_ptr (IDX_W bits, natural wrap).
- Match: combinational compare of cmd_key against all valid slots. Keys are unique, so at most one slot hits; if several were to hit, the highest index wins.
- An accept (cmd_valid & cmd_ready) updates state and loads the response register on the same edge.
- INSERT:
  - Hit: overwrite the value; UPDATED; rsp_value = new value; count unchanged.
  - Miss and not full: write key and value to free_list[rd_ptr], set valid, rd_ptr+1, count+1; INSERTED; rsp_index = allocated slot.
  - Miss and full: no state change; FULL.
- DELETE:
  - Hit: clear valid, write index to free_list[wr_ptr], wr_ptr+1, count−1; DELETED; rsp_value = stored value. Key and value registers are not cleared.
  - Miss: MISS.
- LOOKUP: hit gives HIT with value and index; miss gives MISS with value 0.
- CLEAR: valid vector cleared, pointers 0, count 0, free_list[i]=i for every i, all in one cycle; CLEARED.
- full and empty are decoded from count. count never exceeds MAP_SIZE and never underflows.

## Timing
- Reset (async assert, sync-released by the system): rsp_valid=0, rsp_status=0, rsp_value=0, rsp_index=0, count=0, full=0, empty=1, cmd_ready=1. Valid vector is cleared, pointers are 0, free_list[i]=i.
- Latency: a command accepted at edge N has its response visible after edge N (rsp_valid=1 in cycle N+1).
- cmd_ready = ~rsp_valid | rsp_ready, combinational from rsp_ready. This gives full throughput of one command per cycle when rsp_ready is held high.
- The response is held stable while rsp_valid & ~rsp_ready.
- rsp_valid drops after a response handshake if no new command is accepted on the same edge.
- Back-to-back commands see the state left by the previous accept. Example: INSERT K then LOOKUP K on consecutive cycles gives HIT.
- INSERT when full while the same cycle's consumer drains a response is still FULL, because the occupancy used is the pre-edge value.
- Reset asserted mid-stream discards any pending response and all contents immediately.
- count, full and empty are registered and change on the accept edge.

## Test plan
- Reset then LOOKUP key 0x12 -> MISS, value 0; count=0, empty=1.
- INSERT (0x12,0xBEEF), then LOOKUP 0x12 back-to-back with rsp_ready=1 -> INSERTED idx 0, then HIT value 0xBEEF idx 0, one response per cycle.
- INSERT 16 distinct keys, then INSERT 0x99 -> sixteen INSERTED, full=1, count=16, then FULL with no change. INSERT of an existing key with 0x1111 -> UPDATED.
- DELETE key in slot 5 (value 0x0505) -> DELETED, rsp_value 0x0505, count=15. Next INSERT new key -> INSERTED idx 5 (free-list reuse after wrap).
- Hold rsp_ready=0 for 3 cycles with cmd_valid=1 -> cmd_ready=0, response stable, no second accept. Release -> commands resume, no loss or duplication.
- CLEAR with 10 entries -> CLEARED, count=0, empty=1. Subsequent LOOKUP of a former key -> MISS. Assert reset_n=0 mid-burst -> rsp_valid=0 immediately.
